// File: rtl/sm_bus_arbiter_pkg.sv
// Shared types and defaults for the two-master bus arbiter.
// Holds the FSM encoding, parameter defaults and the round-robin pick rule.
package sm_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arbState_t;

  localparam int DEFAULT_TIMEOUT = 15;
  localparam int DEFAULT_CNT_W   = 4;

  // lg is the index of the master granted last; on a tie the other one wins.
  function automatic logic [1:0] rrPick(input logic [1:0] req, input logic lg);
    logic [1:0] gnt;
    gnt[0] = req[0] & (~req[1] | lg);
    gnt[1] = req[1] & (~req[0] | ~lg);
    return gnt;
  endfunction

endpackage

// File: rtl/sm_bus_arbiter_rr2.sv
// Combinational 2-way round-robin picker.
// Produces a one-hot (or zero) grant from the request pair and last-grant index.
module sm_bus_arbiter_rr2
  import sm_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lg,
  output logic [1:0] gnt
);

  assign gnt = rrPick(req, lg);

endmodule

// File: rtl/sm_bus_arbiter.sv
// Two-master bus arbiter: round-robin grant, one registered slave command in flight,
// bounded slave wait with error completion on timeout.
module sm_bus_arbiter
  import sm_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_req,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ack,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arbState_t         stateReg, stateNext;
  logic              lgReg, lgNext;
  logic [CNT_W-1:0]  cntReg, cntNext;
  logic [1:0]        gnt;
  logic              sReqNext, sWeNext;
  logic [ADDR_W-1:0] sAddrNext;
  logic [DATA_W-1:0] sWdataNext;
  logic              ack0Next, ack1Next, err0Next, err1Next;
  logic [DATA_W-1:0] rdata0Next, rdata1Next;
  logic              respErr;
  logic [DATA_W-1:0] respData;

  sm_bus_arbiter_rr2 uRr2 (
    .req ({m1_req, m0_req}),
    .lg  (lgReg),
    .gnt (gnt)
  );

  always_comb begin
    stateNext  = stateReg;
    lgNext     = lgReg;
    cntNext    = cntReg;
    sReqNext   = s_req;
    sWeNext    = s_we;
    sAddrNext  = s_addr;
    sWdataNext = s_wdata;
    ack0Next   = 1'b0;
    ack1Next   = 1'b0;
    err0Next   = 1'b0;
    err1Next   = 1'b0;
    rdata0Next = m0_rdata;
    rdata1Next = m1_rdata;
    respErr    = 1'b0;
    respData   = '0;
    case (stateReg)
      ARB_IDLE: begin
        if (|gnt) begin
          lgNext     = gnt[1];
          sWeNext    = gnt[1] ? m1_we    : m0_we;
          sAddrNext  = gnt[1] ? m1_addr  : m0_addr;
          sWdataNext = gnt[1] ? m1_wdata : m0_wdata;
          sReqNext   = 1'b1;
          cntNext    = '0;
          stateNext  = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // s_ack takes priority over a timeout on the same edge.
        if (s_ack || cntReg == CNT_LAST) begin
          respErr   = ~s_ack;
          respData  = (s_ack && !s_we) ? s_rdata : '0;
          sReqNext  = 1'b0;
          stateNext = ARB_RESP;
          if (lgReg) begin
            ack1Next   = 1'b1;
            err1Next   = respErr;
            rdata1Next = respData;
          end else begin
            ack0Next   = 1'b1;
            err0Next   = respErr;
            rdata0Next = respData;
          end
        end else begin
          cntNext = cntReg + 1'b1;
        end
      end
      ARB_RESP: stateNext = ARB_IDLE;
      default:  stateNext = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= ARB_IDLE;
      lgReg    <= 1'b1;
      cntReg   <= '0;
      s_req    <= 1'b0;
      s_we     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
      busy     <= 1'b0;
    end else begin
      stateReg <= stateNext;
      lgReg    <= lgNext;
      cntReg   <= cntNext;
      s_req    <= sReqNext;
      s_we     <= sWeNext;
      s_addr   <= sAddrNext;
      s_wdata  <= sWdataNext;
      m0_ack   <= ack0Next;
      m0_err   <= err0Next;
      m0_rdata <= rdata0Next;
      m1_ack   <= ack1Next;
      m1_err   <= err1Next;
      m1_rdata <= rdata1Next;
      busy     <= (stateNext != ARB_IDLE);
    end
  end

endmodule
